// File: rtl/conv_maxpool_if.sv
// -----------------------------------------------------------------------------
// conv_maxpool_if
// Handshake and memory-bus bundle of the max-pool stage.
//   start     request from the convolution stage
//   busy      pool operation in progress
//   done      one-cycle completion pulse
//   crd       read strobe,  caddr_rd read address,  cdata_rd read data
//   cwr       write strobe, caddr_wr write address, cdata_wr write data
//   csel      memory select (001 L0 read, 011 L1 write, 101 L2 write)
// Modports:
//   master  the pooling engine (drives the memory bus)
//   slave   the environment (memories + upstream stage)
// -----------------------------------------------------------------------------
interface conv_maxpool_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic          start;
    logic          busy;
    logic          done;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/conv_maxpool.sv
// -----------------------------------------------------------------------------
// conv_maxpool
// 2x2 stride-2 max-pool of an IMG_W x IMG_W signed feature map held in L0
// memory, writing the (IMG_W/2)^2 result to L1 memory.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset
//   bus    conv_maxpool_if.master: start/busy/done handshake plus the
//          crd/cwr memory bus and csel
// Parameters: IMG_W (power of 2, >= 4), DW data width, AW address width.
// Build option: define MAXPOOL_FLAT_EN to add a FLAT state after WR that
// mirrors every pooled word into L2 memory (csel 3'b101) at the same index.
// -----------------------------------------------------------------------------
module conv_maxpool #(
    parameter int IMG_W = 64,
    parameter int DW    = 20,
    parameter int AW    = 12
) (
    input  logic           clk,
    input  logic           reset,
    conv_maxpool_if.master bus
);
    localparam int OW = IMG_W / 2;
    localparam int CW = $clog2(OW);
    localparam int LW = $clog2(IMG_W);
    localparam logic [CW-1:0] LAST = CW'(OW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_WR,
`ifdef MAXPOOL_FLAT_EN
        S_FLAT,
`endif
        S_FIN
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic signed [DW-1:0] max_q, max_new;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          crd_q, crd_d;
    logic          cwr_q, cwr_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]    csel_q, csel_d;

    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_idx;

    // Outputs are registered, so addresses are formed from the counters the
    // next state will see.
    assign rd_base = (AW'(row_d) << (LW + 1)) + (AW'(col_d) << 1);
    assign wr_idx  = (AW'(row_d) << CW) + AW'(col_d);

    // Word returned during RD1 is the first of the window and loads the
    // running max unconditionally; later words replace it only if strictly
    // greater, so ties keep the held value.
    always_comb begin
        max_new = max_q;
        if (state_q == S_RD1) begin
            max_new = bus.cdata_rd;
        end else if ($signed(bus.cdata_rd) > max_q) begin
            max_new = bus.cdata_rd;
        end
    end

    // State and counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RD0;
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_RD3;
            S_RD3:  state_d = S_WAIT;
            S_WAIT: state_d = S_WR;
`ifdef MAXPOOL_FLAT_EN
            S_WR:   state_d = S_FLAT;
            S_FLAT: begin
`else
            S_WR: begin
`endif
                if (row_q == LAST && col_q == LAST) begin
                    state_d = S_FIN;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = S_RD0;
                    if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                row_d   = '0;
                col_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic, decoded from the state being entered
    always_comb begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = 3'b000;
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        case (state_d)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                busy_d = 1'b1;
                crd_d  = 1'b1;
                csel_d = 3'b001;
                case (state_d)
                    S_RD0:   caddr_rd_d = rd_base;
                    S_RD1:   caddr_rd_d = rd_base + AW'(1);
                    S_RD2:   caddr_rd_d = rd_base + AW'(IMG_W);
                    default: caddr_rd_d = rd_base + AW'(IMG_W + 1);
                endcase
            end
            S_WAIT: busy_d = 1'b1;
            S_WR: begin
                busy_d     = 1'b1;
                cwr_d      = 1'b1;
                csel_d     = 3'b011;
                caddr_wr_d = wr_idx;
                // Entered from WAIT: the fourth word is on cdata_rd now.
                cdata_wr_d = max_new;
            end
`ifdef MAXPOOL_FLAT_EN
            S_FLAT: begin
                // Address and data are held from WR.
                busy_d = 1'b1;
                cwr_d  = 1'b1;
                csel_d = 3'b101;
            end
`endif
            S_FIN: done_d = 1'b1;
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 3'b000;
            max_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
            if (state_q inside {S_RD1, S_RD2, S_RD3, S_WAIT}) begin
                max_q <= max_new;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crd      = crd_q;
    assign bus.cwr      = cwr_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.csel     = csel_q;
endmodule

// File: tb/tb_conv_maxpool.sv
// -----------------------------------------------------------------------------
// tb_conv_maxpool
// Drives full 64x64 frames through conv_maxpool. L0 is modelled with one cycle
// of read latency (junk returned whenever no read was issued). Every expected
// L1/L2 write is queued when a map is built and popped as the write appears.
// Window contents come from a table of {window, expected max} records.
// -----------------------------------------------------------------------------
module tb_conv_maxpool;
    localparam int IMG_W = 64;
    localparam int DW    = 20;
    localparam int AW    = 12;
    localparam int OW    = IMG_W / 2;
    localparam int NPIX  = OW * OW;
`ifdef MAXPOOL_FLAT_EN
    localparam int PP  = 7;
    localparam int WPP = 2;
`else
    localparam int PP  = 6;
    localparam int WPP = 1;
`endif
    localparam int BUSY_EXP = NPIX * PP;

    typedef struct {
        logic [DW-1:0] tl, tr, bl, br, exp;
    } win_t;

    typedef struct {
        logic [2:0]    csel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_maxpool_if #(.DW(DW), .AW(AW)) bus ();

    conv_maxpool #(.IMG_W(IMG_W), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [DW-1:0] l0 [IMG_W*IMG_W];
    logic [DW-1:0] l1 [NPIX];
    logic [DW-1:0] l2 [NPIX];
    wr_t  exp_q [$];
    win_t tbl [8];

    int checks = 0;
    int errors = 0;
    int wr_cnt, busy_cnt, done_cnt, viol;
    bit blocked  = 1'b0;
    bit rst_abort = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_cwr  = 1'b0;
    logic [2:0] prev_csel = 3'b000;

    // L0 memory: data for an address issued in cycle N appears in cycle N+1.
    always @(posedge clk) begin
        if (bus.crd === 1'b1) bus.cdata_rd <= l0[bus.caddr_rd];
        else                  bus.cdata_rd <= DW'($urandom);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: scoreboard for writes, protocol rules for every cycle.
    always @(negedge clk) begin
        wr_t e;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.cwr === 1'b1) begin
            wr_cnt++;
            if (bus.csel == 3'b011 && int'(bus.caddr_wr) < NPIX) l1[bus.caddr_wr] = bus.cdata_wr;
            if (bus.csel == 3'b101 && int'(bus.caddr_wr) < NPIX) l2[bus.caddr_wr] = bus.cdata_wr;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_extra: got csel=%b addr=%0d data=%h, expected no write",
                         bus.csel, bus.caddr_wr, bus.cdata_wr);
            end else begin
                e = exp_q.pop_front();
                if (bus.csel !== e.csel || bus.caddr_wr !== e.addr || bus.cdata_wr !== e.data) begin
                    errors++;
                    $display("FAIL write: got csel=%b addr=%0d data=%h, expected csel=%b addr=%0d data=%h",
                             bus.csel, bus.caddr_wr, bus.cdata_wr, e.csel, e.addr, e.data);
                end
            end
        end
        if (bus.crd === 1'b1 && bus.cwr === 1'b1) viol++;
        if (bus.crd === 1'b1 && bus.csel !== 3'b001) viol++;
        if (bus.cwr === 1'b1 && bus.csel !== 3'b011 && bus.csel !== 3'b101) viol++;
`ifndef MAXPOOL_FLAT_EN
        if (bus.csel === 3'b101) viol++;
`endif
        if (bus.crd !== 1'b1 && bus.cwr !== 1'b1 && bus.csel !== 3'b000 && reset === 1'b1) viol++;
        if (prev_cwr === 1'b1 && bus.cwr === 1'b1 &&
            !(WPP == 2 && prev_csel == 3'b011 && bus.csel == 3'b101)) viol++;
        if (bus.done === 1'b1 && bus.busy === 1'b1) viol++;
        if (prev_busy === 1'b1 && bus.busy === 1'b0 && bus.done !== 1'b1 && !rst_abort) viol++;
        if (blocked && (bus.crd !== 1'b0 || bus.cwr !== 1'b0)) viol++;
        prev_busy = bus.busy;
        prev_cwr  = bus.cwr;
        prev_csel = bus.csel;
    end

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic signed [DW-1:0] m;
        m = a;
        if ($signed(b) > m) m = b;
        if ($signed(c) > m) m = c;
        if ($signed(d) > m) m = d;
        return m;
    endfunction

    task automatic push_exp(input int idx, input logic [DW-1:0] v);
        exp_q.push_back('{3'b011, AW'(idx), v});
        if (WPP == 2) exp_q.push_back('{3'b101, AW'(idx), v});
    endtask

    task automatic clear_outs();
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) begin
            l1[i] = '0;
            l2[i] = '0;
        end
    endtask

    task automatic build_ramp();
        int b;
        clear_outs();
        for (int a = 0; a < IMG_W*IMG_W; a++) l0[a] = DW'(a);
        for (int p = 0; p < NPIX; p++) begin
            b = 2*(p/OW)*IMG_W + 2*(p%OW);
            push_exp(p, max4(l0[b], l0[b+1], l0[b+IMG_W], l0[b+IMG_W+1]));
        end
    endtask

    // Pixel p takes its window from table entry base + p%4.
    task automatic build_table(input int base);
        int b;
        win_t w;
        clear_outs();
        for (int p = 0; p < NPIX; p++) begin
            w = tbl[base + p%4];
            b = 2*(p/OW)*IMG_W + 2*(p%OW);
            l0[b]         = w.tl;
            l0[b+1]       = w.tr;
            l0[b+IMG_W]   = w.bl;
            l0[b+IMG_W+1] = w.br;
            push_exp(p, w.exp);
        end
    endtask

    // One frame. Cycle 1 is the first busy cycle; a start raised at cycle k
    // is sampled at the edge ending cycle k. reset_at>0 aborts the frame.
    task automatic run_frame(input string name, input int ex_a, input int ex_b,
                             input int ex_c, input int reset_at);
        int limit;
        wr_cnt = 0; busy_cnt = 0; done_cnt = 0; viol = 0;
        blocked = 1'b0; rst_abort = 1'b0;
        limit = (reset_at > 0) ? reset_at + 10 : BUSY_EXP + 21;
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, "_first_read"}, 64'({bus.crd, bus.caddr_rd}), 64'({1'b1, 12'd0}));
        for (int cyc = 2; cyc <= limit; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == ex_a || cyc == ex_b || cyc == ex_c);
            if (reset_at > 0 && cyc == reset_at) begin
                reset = 1'b0;
                rst_abort = 1'b1;
            end
            if (reset_at > 0 && cyc == reset_at + 1) begin
                chk({name, "_outputs_cleared"},
                    64'({bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd,
                         bus.caddr_wr, bus.cdata_wr, bus.csel}), 64'd0);
                blocked = 1'b1;
            end
        end
        bus.start = 1'b0;
        $display("frame %s: writes=%0d busy_cycles=%0d done_pulses=%0d pending=%0d",
                 name, wr_cnt, busy_cnt, done_cnt, exp_q.size());
    endtask

    task automatic frame_checks(input string name);
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(BUSY_EXP));
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_write_count"}, 64'(wr_cnt), 64'(NPIX*WPP));
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_protocol"}, 64'(viol), 64'd0);
    endtask

    initial begin
        int exp_wr;
        int diff;
        // TL, TR, BL, BR, expected max
        tbl[0] = '{20'h0A000, 20'h00100, 20'h00100, 20'h00100, 20'h0A000};
        tbl[1] = '{20'h00100, 20'h0A000, 20'h00100, 20'h00100, 20'h0A000};
        tbl[2] = '{20'h00100, 20'h00100, 20'h0A000, 20'h00100, 20'h0A000};
        tbl[3] = '{20'h00100, 20'h00100, 20'h00100, 20'h0A000, 20'h0A000};
        tbl[4] = '{20'hFFFFF, 20'h80000, 20'h80001, 20'hFFFFE, 20'hFFFFF};
        tbl[5] = '{20'h80000, 20'h80000, 20'h80000, 20'h80000, 20'h80000};
        tbl[6] = '{20'h7FFFF, 20'h80000, 20'h00000, 20'hFFFFF, 20'h7FFFF};
        tbl[7] = '{20'h80001, 20'h80000, 20'h80003, 20'h80002, 20'h80003};

        reset = 1'b0;
        bus.start = 1'b1;
        build_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            64'({bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd,
                 bus.caddr_wr, bus.cdata_wr, bus.csel}), 64'd0);

        // Ramp map; start stays high across reset release.
        run_frame("ramp", 0, 0, 0, 0);
        frame_checks("ramp");
        chk("ramp_L1_0",    64'(l1[0]),    64'd65);
        chk("ramp_L1_1",    64'(l1[1]),    64'd67);
        chk("ramp_L1_31",   64'(l1[31]),   64'd127);
        chk("ramp_L1_32",   64'(l1[32]),   64'd193);
        chk("ramp_L1_1023", 64'(l1[1023]), 64'd4095);
        if (WPP == 2) begin
            diff = 0;
            for (int i = 0; i < NPIX; i++) if (l2[i] !== l1[i]) diff++;
            chk("ramp_L2_eq_L1", 64'(diff), 64'd0);
            chk("ramp_L2_1023", 64'(l2[1023]), 64'd4095);
        end

        // Rotating peak; stray starts mid-run and in the done cycle.
        build_table(0);
        run_frame("quadrant", 10, 3000, BUSY_EXP + 1, 0);
        frame_checks("quadrant");

        // Signed windows, aborted by reset at cycle 2000.
        build_table(4);
        run_frame("signed_abort", 0, 0, 0, 2000);
        exp_wr = 0;
        for (int c = 1; c <= 2000; c++) if ((c - 1) % PP >= 5) exp_wr++;
        chk("abort_write_count", 64'(wr_cnt), 64'(exp_wr));
        chk("abort_done_pulses", 64'(done_cnt), 64'd0);
        chk("abort_protocol", 64'(viol), 64'd0);

        // Clean rerun after the abort.
        build_table(4);
        run_frame("signed", 0, 0, 0, 0);
        frame_checks("signed");
        chk("signed_L1_0", 64'(l1[0]), 64'h0FFFFF);
        chk("signed_L1_2", 64'(l1[2]), 64'h07FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
